// File: rtl/serial_alu_executor.sv
// ---------------------------------------------------------------------------
// serial_alu_executor
//
// Multi-cycle execution unit sitting between decode and write-back. Logic and
// arithmetic operations finish in one cycle. Logical shifts are done one bit
// per cycle in an internal shift register, so no barrel shifter is required.
// A start/busy/done handshake connects the unit to the core sequencer.
//
// Ports
//   clk             in   rising-edge clock
//   reset           in   asynchronous, active-high reset
//   start_i         in   request, sampled only while idle
//   ALU_Operation_i in   4-bit op code from the ALU control decoder
//   A_i             in   operand A (also the shift source)
//   B_i             in   operand B; B_i[SHW-1:0] is the shift amount
//   busy_o          out  high while a serial shift is in progress
//   done_o          out  one-cycle pulse when ALU_Result_o is updated
//   ALU_Result_o    out  registered result, held until the next completion
//   Zero_o          out  ALU_Result_o == 0
// ---------------------------------------------------------------------------
module serial_alu_executor #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic [3:0]            ALU_Operation_i,
    input  logic [DATA_WIDTH-1:0] A_i,
    input  logic [DATA_WIDTH-1:0] B_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] ALU_Result_o,
    output logic                  Zero_o
);

    localparam int SHW = $clog2(DATA_WIDTH);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_LUI = 4'b0101;
    localparam logic [3:0] OP_SRL = 4'b0110;
    localparam logic [3:0] OP_SLL = 4'b0111;

    localparam logic [SHW-1:0]        CNT_ZERO  = {SHW{1'b0}};
    localparam logic [SHW-1:0]        CNT_ONE   = {{(SHW-1){1'b0}}, 1'b1};
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Single-cycle result. A shift reaching this path has a zero amount, so
    // it simply passes A through.
    function automatic logic [DATA_WIDTH-1:0] alu_one_cycle(
        input logic [3:0]            op,
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        logic [DATA_WIDTH-1:0] r;
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_LUI:  r = b;
            OP_SRL:  r = a;
            OP_SLL:  r = a;
            default: r = DATA_ZERO;
        endcase
        return r;
    endfunction

    state_t                state_q,  state_d;
    logic                  left_q,   left_d;     // 1: SLL, 0: SRL
    logic [DATA_WIDTH-1:0] shreg_q,  shreg_d;
    logic [SHW-1:0]        cnt_q,    cnt_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  done_q,   done_d;

    logic                  is_shift_s;
    logic [SHW-1:0]        amount_s;
    logic [DATA_WIDTH-1:0] shifted_s;

    // Decode the request and form the one-bit shift of the working register.
    always_comb begin
        is_shift_s = (ALU_Operation_i == OP_SRL) || (ALU_Operation_i == OP_SLL);
        amount_s   = B_i[SHW-1:0];
        if (left_q) begin
            shifted_s = {shreg_q[DATA_WIDTH-2:0], 1'b0};
        end else begin
            shifted_s = {1'b0, shreg_q[DATA_WIDTH-1:1]};
        end
    end

    // Next-state logic for the IDLE/SHIFT sequencer and its datapath.
    always_comb begin
        state_d  = state_q;
        left_d   = left_q;
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if (is_shift_s && (amount_s != CNT_ZERO)) begin
                        state_d = ST_SHIFT;
                        left_d  = (ALU_Operation_i == OP_SLL);
                        shreg_d = A_i;
                        cnt_d   = amount_s;
                    end else begin
                        result_d = alu_one_cycle(ALU_Operation_i, A_i, B_i);
                        done_d   = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                // start_i is deliberately not looked at here: no queuing.
                shreg_d = shifted_s;
                cnt_d   = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    result_d = shifted_s;
                    done_d   = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight shift.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            left_q   <= 1'b0;
            shreg_q  <= DATA_ZERO;
            cnt_q    <= CNT_ZERO;
            result_q <= DATA_ZERO;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            left_q   <= left_d;
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign busy_o       = (state_q == ST_SHIFT);
    assign done_o       = done_q;
    assign ALU_Result_o = result_q;
    assign Zero_o       = (result_q == DATA_ZERO);

endmodule
